blram_dp: RTL and testbench
===========================

# blram_dp

Parametrised dual-port block RAM, successor to the single-port `blram` attached to `VerySimpleCPU`. Port A is a read/write CPU port with byte enables; port B is a read-only port for a debug/display or DMA reader. A sequencer clears the whole array on request. The block sits between the CPU and its program/data store, and the bench preloads it through the `memory` array.

## Interface
Parameters:
- `DATA_W`, 32: word width. Must be a multiple of 8.
- `ADDR_W`, 10: address width on both ports.
- `DEPTH`, 1024: number of words. Must be ≤ 2^ADDR_W.
- `RDW_MODE`, 0: read-during-write result on a same-address collision. 0 = old data, 1 = new data.

Ports:
- `clk`  in  1  clock. Everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_a_we`  in  1  port A write enable.
- `i_a_be`  in  DATA_W/8  port A byte enables. Bit k covers bits [8k+7:8k].
- `i_a_addr`  in  ADDR_W  port A address.
- `i_a_data_in`  in  DATA_W  port A write data.
- `o_a_data_out`  out  DATA_W  port A read data.
- `i_b_addr`  in  ADDR_W  port B address.
- `o_b_data_out`  out  DATA_W  port B read data.
- `i_clr`  in  1  clear request, single-cycle pulse.
- `o_busy`  out  1  high while a clear is in progress.
- `o_clr_done`  out  1  one-cycle pulse when a clear completes.

## Operation
- Storage is `reg [DATA_W-1:0] memory[0:DEPTH-1]`. The name `memory` is fixed so benches can preload it and inspect it hierarchically.
- Reset does not modify `memory`, so preloaded program contents survive reset.
- Reset forces `o_a_data_out=0`, `o_b_data_out=0`, `o_busy=0`, `o_clr_done=0`, sequencer state ST_IDLE and clear counter 0.
- **Port A write:** when `i_a_we=1` in ST_IDLE, byte k of `memory[i_a_addr]` updates only if `i_a_be[k]=1`. `i_a_we=1` with `i_a_be=0` writes nothing.
- **Port A read:** port A reads every cycle. A read on the same cycle as a write to the same address returns old or merged-new data according to `RDW_MODE`.
- **Port B read:** port B reads every cycle. When port B reads the address port A is writing in that cycle, the result follows `RDW_MODE`. With RDW_MODE=1, unwritten bytes come from the old word.
- **Out-of-range address** (`addr ≥ DEPTH`): writes are ignored and reads return 0.
- **Sequencer states:** ST_IDLE and ST_CLEAR.
  - ST_IDLE → ST_CLEAR on `i_clr=1`.
  - In ST_CLEAR, each cycle writes 0 to `memory[cnt]` and increments `cnt`.
  - When `cnt=DEPTH-1` is written, the sequencer returns to ST_IDLE, pulses `o_clr_done` and resets `cnt` to 0.
- **During ST_CLEAR:**
  - `o_busy=1`.
  - Port A writes are dropped. They are not queued.
  - Both read outputs return 0.
  - `i_clr` is ignored.
- **Reset mid-clear:** the sequencer aborts to ST_IDLE and the array stays partially cleared. There is no `o_clr_done` pulse.

## Timing
- Read latency is 1 cycle: the address sampled at edge N gives data valid after edge N (same as `blram`).
- Write commits at the sampling edge, so a read of the same address on the next cycle returns the new data.
- **Clear timing:**
  - `i_clr` sampled at edge N sets `o_busy=1` after edge N.
  - Addresses 0..DEPTH-1 are written at edges N+1..N+DEPTH.
  - `o_clr_done=1` and `o_busy=0` after edge N+DEPTH.
  - `o_clr_done` stays high for exactly one cycle.
- Port A operations issued in the cycle where `o_busy` falls are accepted.
- **Simultaneous `rst` and `i_clr`:** reset wins.

## Configuration
- `BLRAM_OUT_REG_EN` defined:
  - An extra output register is added on both read ports.
  - Read latency becomes 2 cycles.
  - The extra registers reset to 0.
  - Clear-time zeroing applies at the final output.
  - `o_clr_done` is delayed one cycle to align with the data path.
- `BLRAM_OUT_REG_EN` undefined: latency is 1 and no extra registers are present.

## Structure
- Package `blram_pkg`:
  - state enum {ST_IDLE, ST_CLEAR}
  - constants RDW_OLD=0 and RDW_NEW=1
  - function computing the byte-merged write word from old data, new data and `be`
- Sub-module `blram_clr_seq`: owns the state, the counter, `o_busy` and `o_clr_done`. It drives the clear write address and write strobe to the array.

## Test plan
1. Preload words 0..13 with program constants, then pulse `rst` for 10 cycles → `memory[0]` and `memory[13]` are unchanged and both outputs read 0 during reset.
2. Port A write 0xAABBCCDD to addr 50 with be=4'b0101 over 0x11223344 → the next read returns 0x11BB33DD.
3. RDW collision at addr 7, old value 5, port A writes 9 while port B reads 7:
   - RDW_MODE=0: `o_b_data_out=5`.
   - RDW_MODE=1: `o_b_data_out=9`.
   - Port A read of 7 in the following cycle returns 9.
4. DEPTH=600, ADDR_W=10: write to addr 700 → no array change, and reading 700 returns 0.
5. Pulse `i_clr` with DEPTH=1024 → `o_busy` is high for 1024 cycles, `o_clr_done` pulses once, then addr 511 reads 0. A port A write during the clear is dropped.
6. Assert `rst` after 100 clear cycles → `o_busy=0` on the next cycle, there is no `o_clr_done` pulse, addr 50 reads 0 and addr 500 retains its value.

Source files
------------

// File: rtl/blram_pkg.sv
// Shared types and helpers for the dual-port block RAM and its clear sequencer.
package blram_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } seq_state_e;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Widest word the merge helper handles; callers size-cast in and slice out.
    localparam int MERGE_MAX_W = 256;

    function automatic logic [MERGE_MAX_W-1:0] merge_bytes(
        input logic [MERGE_MAX_W-1:0]   old_word,
        input logic [MERGE_MAX_W-1:0]   new_word,
        input logic [MERGE_MAX_W/8-1:0] be
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int k = 0; k < MERGE_MAX_W/8; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = new_word[8*k +: 8];
            end else begin
                merged[8*k +: 8] = old_word[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/blram_clr_seq.sv
// Clear sequencer: walks every word address once, zeroing it, then pulses done.
module blram_clr_seq
    import blram_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clr,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr,
    output logic              o_busy,
    output logic              o_clr_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_clr) begin
                    state_d = ST_CLEAR;
                    cnt_d   = {ADDR_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    busy_d  = 1'b0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = {ADDR_W{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {ADDR_W{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // Sequencer state, counter and status flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {ADDR_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_clr_we   = (state_q == ST_CLEAR);
    assign o_clr_addr = cnt_q;
    assign o_busy     = busy_q;
    assign o_clr_done = done_q;

endmodule

// File: rtl/blram_dp.sv
// Dual-port block RAM: port A read/write with byte enables, port B read-only,
// whole-array clear. Define BLRAM_OUT_REG_EN for an extra output register stage.
module blram_dp
    import blram_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 10,
    parameter int DEPTH    = 1024,
    parameter int RDW_MODE = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_a_we,
    input  logic [DATA_W/8-1:0] i_a_be,
    input  logic [ADDR_W-1:0]   i_a_addr,
    input  logic [DATA_W-1:0]   i_a_data_in,
    output logic [DATA_W-1:0]   o_a_data_out,
    input  logic [ADDR_W-1:0]   i_b_addr,
    output logic [DATA_W-1:0]   o_b_data_out,
    input  logic                i_clr,
    output logic                o_busy,
    output logic                o_clr_done
);

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    reg [DATA_W-1:0] memory [0:DEPTH-1];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              clr_done;

    blram_clr_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clr_seq (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (i_clr),
        .o_clr_we   (clr_we),
        .o_clr_addr (clr_addr),
        .o_busy     (o_busy),
        .o_clr_done (clr_done)
    );

    logic                   a_in_range, b_in_range, a_wr, b_hit;
    logic [DATA_W-1:0]      a_word, b_word, merged;
    logic [MERGE_MAX_W-1:0] merged_ext;
    logic [DATA_W-1:0]      a_data_q, a_data_d, b_data_q, b_data_d;

    // Address decode, write qualification and read-during-write selection.
    always_comb begin
        a_in_range = ({1'b0, i_a_addr} < DEPTH_L);
        b_in_range = ({1'b0, i_b_addr} < DEPTH_L);
        a_word     = a_in_range ? memory[i_a_addr] : {DATA_W{1'b0}};
        b_word     = b_in_range ? memory[i_b_addr] : {DATA_W{1'b0}};
        merged_ext = merge_bytes(MERGE_MAX_W'(a_word), MERGE_MAX_W'(i_a_data_in),
                                 (MERGE_MAX_W/8)'(i_a_be));
        merged     = merged_ext[DATA_W-1:0];
        a_wr       = i_a_we && a_in_range && !clr_we && !rst;
        b_hit      = a_wr && (i_b_addr == i_a_addr);
        if (clr_we) begin
            a_data_d = {DATA_W{1'b0}};
            b_data_d = {DATA_W{1'b0}};
        end else begin
            a_data_d = (a_wr && RDW_MODE == RDW_NEW) ? merged : a_word;
            b_data_d = (b_hit && RDW_MODE == RDW_NEW) ? merged : b_word;
        end
    end

    // Array update: clear sequencer has priority over port A (which it blocks anyway).
    always_ff @(posedge clk) begin
        if (clr_we && !rst) begin
            memory[clr_addr] <= {DATA_W{1'b0}};
        end else if (a_wr) begin
            memory[i_a_addr] <= merged;
        end
    end

    // First-stage read data registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_data_q <= {DATA_W{1'b0}};
            b_data_q <= {DATA_W{1'b0}};
        end else begin
            a_data_q <= a_data_d;
            b_data_q <= b_data_d;
        end
    end

`ifdef BLRAM_OUT_REG_EN
    logic [DATA_W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic              done_dly_q;

    // Second stage keeps outputs zero for the whole clear, not just the first stage.
    always_comb begin
        if (clr_we) begin
            a_out_d = {DATA_W{1'b0}};
            b_out_d = {DATA_W{1'b0}};
        end else begin
            a_out_d = a_data_q;
            b_out_d = b_data_q;
        end
    end

    // Output register stage and done-pulse alignment.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_out_q    <= {DATA_W{1'b0}};
            b_out_q    <= {DATA_W{1'b0}};
            done_dly_q <= 1'b0;
        end else begin
            a_out_q    <= a_out_d;
            b_out_q    <= b_out_d;
            done_dly_q <= clr_done;
        end
    end

    assign o_a_data_out = a_out_q;
    assign o_b_data_out = b_out_q;
    assign o_clr_done   = done_dly_q;
`else
    assign o_a_data_out = a_data_q;
    assign o_b_data_out = b_data_q;
    assign o_clr_done   = clr_done;
`endif

endmodule

// File: tb/tb_blram_dp.sv
// Directed bench for blram_dp: two instances (old-data 1024 words, new-data 600 words)
// driven from the same stimulus.
module tb_blram_dp;

    logic        clk;
    logic        rst;
    logic        a_we;
    logic [3:0]  a_be;
    logic [9:0]  a_addr;
    logic [31:0] a_data;
    logic [9:0]  b_addr;
    logic        clr;

    logic [31:0] a0, b0, a1, b1;
    logic        busy0, done0, busy1, done1;

    int n_cmp  = 0;
    int n_fail = 0;
    int busy_cnt;
    int done_cnt;

    blram_dp #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .RDW_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr),
        .i_a_data_in(a_data), .o_a_data_out(a0), .i_b_addr(b_addr), .o_b_data_out(b0),
        .i_clr(clr), .o_busy(busy0), .o_clr_done(done0)
    );

    blram_dp #(.DATA_W(32), .ADDR_W(10), .DEPTH(600), .RDW_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .i_a_we(a_we), .i_a_be(a_be), .i_a_addr(a_addr),
        .i_a_data_in(a_data), .o_a_data_out(a1), .i_b_addr(b_addr), .o_b_data_out(b1),
        .i_clr(clr), .o_busy(busy1), .o_clr_done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        a_we   = 1'b0;
        a_be   = 4'h0;
        a_addr = 10'd0;
        a_data = 32'h0;
        b_addr = 10'd13;
        clr    = 1'b0;
        for (int i = 0; i < 14; i++) begin
            dut0.memory[i] = 32'h0000_1000 + i;
            dut1.memory[i] = 32'h0000_1000 + i;
        end
        dut0.memory[50]  = 32'h1122_3344;
        dut1.memory[50]  = 32'h1122_3344;
        dut0.memory[7]   = 32'd5;
        dut1.memory[7]   = 32'd5;
        dut1.memory[188] = 32'h0000_0188;
        dut0.memory[511] = 32'hCAFE_F00D;

        // Reset held for 10 cycles: outputs zero, preload intact.
        for (int i = 0; i < 10; i++) begin
            tick();
            check("rst_a0", a0, 32'h0);
            check("rst_b0", b0, 32'h0);
        end
        check("rst_busy", {31'b0, busy0}, 32'h0);
        check("rst_done", {31'b0, done0}, 32'h0);
        check("rst_mem0", dut0.memory[0], 32'h0000_1000);
        check("rst_mem13", dut0.memory[13], 32'h0000_100D);
        rst = 1'b0;
        tick();
        check("rd_a0_addr0", a0, 32'h0000_1000);
        check("rd_b0_addr13", b0, 32'h0000_100D);
        check("rd_b1_addr13", b1, 32'h0000_100D);

        // Byte-enabled write with both ports on the written address.
        a_we = 1'b1; a_be = 4'b0101; a_addr = 10'd50; a_data = 32'hAABB_CCDD; b_addr = 10'd50;
        tick();
        check("be_a0_old", a0, 32'h1122_3344);
        check("be_b0_old", b0, 32'h1122_3344);
        check("be_a1_new", a1, 32'h11BB_33DD);
        check("be_b1_new", b1, 32'h11BB_33DD);
        a_we = 1'b0;
        tick();
        check("be_a0_after", a0, 32'h11BB_33DD);
        check("be_a1_after", a1, 32'h11BB_33DD);

        // Read-during-write collision at address 7.
        a_we = 1'b1; a_be = 4'hF; a_addr = 10'd7; a_data = 32'd9; b_addr = 10'd7;
        tick();
        check("rdw_b0_old", b0, 32'd5);
        check("rdw_b1_new", b1, 32'd9);
        a_we = 1'b0;
        tick();
        check("rdw_a0_next", a0, 32'd9);
        check("rdw_a1_next", a1, 32'd9);

        // Write enable with no byte enables changes nothing.
        a_we = 1'b1; a_be = 4'h0; a_data = 32'hFFFF_FFFF;
        tick();
        a_we = 1'b0;
        tick();
        check("be0_a0", a0, 32'd9);

        // Address 700: out of range for the 600-word instance only.
        a_we = 1'b1; a_be = 4'hF; a_addr = 10'd700; a_data = 32'h1234_5678; b_addr = 10'd700;
        tick();
        check("oor_a1_wr", a1, 32'h0);
        check("oor_b1_wr", b1, 32'h0);
        a_we = 1'b0;
        tick();
        check("oor_a1_rd", a1, 32'h0);
        check("oor_mem188", dut1.memory[188], 32'h0000_0188);
        check("inr_a0_700", a0, 32'h1234_5678);

        // Full clear; port A write to an already-cleared word mid-clear must be dropped.
        a_addr = 10'd511; b_addr = 10'd511;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_busy_rise", {31'b0, busy0}, 32'h1);
        busy_cnt = 1;
        done_cnt = 0;
        for (int k = 0; k < 1100; k++) begin
            if (k == 100) begin
                a_we = 1'b1; a_be = 4'hF; a_addr = 10'd3; a_data = 32'd77;
            end else begin
                a_we = 1'b0; a_addr = 10'd511;
            end
            tick();
            if (k == 200) check("clr_a0_zero", a0, 32'h0);
            if (done0) done_cnt++;
            if (busy0) busy_cnt++;
            else break;
        end
        check("clr_busy_cycles", busy_cnt, 32'd1024);
        check("clr_done_count", done_cnt, 32'd1);
        check("clr_done_at_fall", {31'b0, done0}, 32'h1);
        // Write issued in the cycle busy falls is accepted.
        a_we = 1'b1; a_be = 4'hF; a_addr = 10'd20; a_data = 32'h0000_ABCD;
        tick();
        check("clr_done_one_cycle", {31'b0, done0}, 32'h0);
        a_we = 1'b0;
        tick();
        check("post_clr_wr20", a0, 32'h0000_ABCD);
        a_addr = 10'd511;
        tick();
        check("post_clr_511", a0, 32'h0);
        a_addr = 10'd3;
        tick();
        check("clr_dropped_wr3", a0, 32'h0);

        // Reset 100 cycles into a clear: abort, no done, partial clear.
        a_we = 1'b1; a_be = 4'hF; a_addr = 10'd50; a_data = 32'h0000_5050;
        tick();
        a_we = 1'b0;
        dut0.memory[500] = 32'hDEAD_BEEF;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", {31'b0, busy0}, 32'h0);
        check("abort_done", {31'b0, done0}, 32'h0);
        rst = 1'b0; a_addr = 10'd50; b_addr = 10'd500;
        tick();
        check("abort_a0_50", a0, 32'h0);
        check("abort_b0_500", b0, 32'hDEAD_BEEF);
        check("abort_no_done", {31'b0, done0}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
